// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: in-flight branch FIFO, mispredict flush/redirect and predictor update port.
// Optional BRC_STATS_EN adds branch and mispredict counters.
module branch_resolve_ctrl #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      alloc_valid,
    output logic                      alloc_ready,
    input  logic [31:0]               alloc_pc,
    input  logic                      alloc_pred,
    input  logic                      res_valid,
    output logic                      res_ready,
    input  logic                      res_taken,
    input  logic [31:0]               res_target,
    output logic                      flush,
    output logic [31:0]               redirect_pc,
    output logic                      upd_valid,
    input  logic                      upd_ready,
    output logic [IDX_W-1:0]          upd_idx,
    output logic                      upd_taken,
    output logic                      upd_init,
    output logic                      busy,
`ifdef BRC_STATS_EN
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic [31:0]               stat_branches,
    output logic [31:0]               stat_mispredicts
`else
    output logic [$clog2(DEPTH):0]    occupancy
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_C = (PTR_W+1)'(DEPTH);

    typedef enum logic {INIT, RUN} state_e;

    state_e            state_q;
    logic [IDX_W-1:0]  sweep_q;
    logic [31:0]       pc_q [DEPTH];
    logic [DEPTH-1:0]  pred_q;
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [PTR_W:0]    occ_q;
    logic              upd_pend_q;
    logic [IDX_W-1:0]  upd_idx_q;
    logic              upd_taken_q;
    logic              flush_q;
    logic [31:0]       redirect_q;

    logic              run;
    logic              alloc_fire;
    logic              res_fire;
    logic              mispredict;
    logic [31:0]       head_pc;
    logic              head_pred;
    logic [31:0]       fix_pc_d;

    always_comb begin
        run        = (state_q == RUN);
        head_pc    = pc_q[head_q];
        head_pred  = pred_q[head_q];
        alloc_ready = run && (occ_q < FULL_C);
        // A resolve needs somewhere to put its predictor update.
        res_ready  = run && (occ_q != '0) && (!upd_pend_q || upd_ready);
        alloc_fire = alloc_valid && alloc_ready;
        res_fire   = res_valid && res_ready;
        mispredict = res_fire && (res_taken != head_pred);
        fix_pc_d   = res_taken ? res_target : (head_pc + 32'd4);
    end

    // The init request must read as idle while reset is held, yet be live on the very first cycle after release.
    always_comb begin
        upd_valid   = ((state_q == INIT) && !reset) || upd_pend_q;
        upd_init    = (state_q == INIT) && !reset;
        upd_idx     = (state_q == INIT) ? sweep_q : upd_idx_q;
        upd_taken   = upd_taken_q;
        busy        = (state_q == INIT);
        flush       = flush_q;
        redirect_pc = redirect_q;
        occupancy   = occ_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= INIT;
            sweep_q     <= '0;
            pred_q      <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            occ_q       <= '0;
            upd_pend_q  <= 1'b0;
            upd_idx_q   <= '0;
            upd_taken_q <= 1'b0;
            flush_q     <= 1'b0;
            redirect_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i] <= '0;
            end
        end else begin
            flush_q    <= mispredict;
            redirect_q <= mispredict ? fix_pc_d : 32'd0;
            if (state_q == INIT) begin
                if (upd_ready) begin
                    sweep_q <= sweep_q + 1'b1;
                    if (&sweep_q) begin
                        state_q <= RUN;
                    end
                end
            end else begin
                if (res_fire) begin
                    upd_pend_q  <= 1'b1;
                    upd_idx_q   <= head_pc[IDX_W+1:2];
                    upd_taken_q <= res_taken;
                end else if (upd_ready) begin
                    upd_pend_q <= 1'b0;
                end
                // A mispredict squashes every younger entry, including one arriving this cycle.
                if (mispredict) begin
                    head_q <= tail_q;
                    occ_q  <= '0;
                end else begin
                    if (alloc_fire) begin
                        pc_q[tail_q]   <= alloc_pc;
                        pred_q[tail_q] <= alloc_pred;
                        tail_q         <= tail_q + 1'b1;
                    end
                    if (res_fire) begin
                        head_q <= head_q + 1'b1;
                    end
                    case ({alloc_fire, res_fire})
                        2'b10:   occ_q <= occ_q + 1'b1;
                        2'b01:   occ_q <= occ_q - 1'b1;
                        default: occ_q <= occ_q;
                    endcase
                end
            end
        end
    end

`ifdef BRC_STATS_EN
    logic [31:0] stat_br_q;
    logic [31:0] stat_mis_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            if (res_fire) begin
                stat_br_q <= stat_br_q + 32'd1;
            end
            if (mispredict) begin
                stat_mis_q <= stat_mis_q + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;
`endif

endmodule
